// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared constants and types for the instruction sequencer.
// Opcodes, FSM state encoding, instruction field slices, opcode classifier.
package instr_seq_pkg;

    localparam logic [5:0] OP_LOAD   = 6'd7;
    localparam logic [5:0] OP_STORE  = 6'd8;
    localparam logic [5:0] OP_BRANCH = 6'd9;
    localparam logic [5:0] OP_HALT   = 6'd63;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 5;
    localparam int TGT_LSB = 6;
    localparam int TGT_MSB = 21;
    localparam int TGT_W   = TGT_MSB - TGT_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_HALT
    } op_class_t;

    function automatic op_class_t decode_op(
        input logic [31:0] instr
    );
        logic [5:0] opc;
        op_class_t  c;
        opc = instr[OPC_MSB:OPC_LSB];
        unique case (1'b1)
            opc == OP_LOAD:   c = CL_LOAD;
            opc == OP_STORE:  c = CL_STORE;
            opc == OP_BRANCH: c = CL_BRANCH;
            opc == OP_HALT:   c = CL_HALT;
            default:          c = CL_ALU;
        endcase
        return c;
    endfunction

    function automatic logic [TGT_W-1:0] branch_tgt(
        input logic [31:0] instr
    );
        return instr[TGT_MSB:TGT_LSB];
    endfunction

endpackage

// File: rtl/instr_seq_pc.sv
// instr_seq_pc: program counter with reset load, branch load and increment.
// Ports: clk, rst_n (sync, active low), load/load_val, inc, pc.
module instr_seq_pc #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // Load wins over increment; increment wraps naturally at 2^PC_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM.
// Ports: run, imem req/addr/ready/rdata, ir, pc, alu_en, zero_flag,
//        dmem rd/wr/ready, rf_we, halt, state, retired.
// Macro INSTR_SEQ_PERF_EN enables the retired-instruction counter.
module instr_sequencer #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic [PC_W-1:0] pc,
    output logic            alu_en,
    input  logic            zero_flag,
    output logic            dmem_rd,
    output logic            dmem_wr,
    input  logic            dmem_ready,
    output logic            rf_we,
    output logic            halt,
    output logic [2:0]      state,
    output logic [31:0]     retired
);

    import instr_seq_pkg::*;

    state_t          state_q;
    state_t          state_d;
    op_class_t       op;
    logic            pc_load;
    logic            pc_inc;
    logic [PC_W-1:0] pc_tgt;

    assign op        = decode_op(ir);
    assign pc_tgt    = PC_W'(branch_tgt(ir));
    assign state     = state_q;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (op == CL_HALT) state_d = ST_HALTED;
                else               state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (op == CL_LOAD || op == CL_STORE)
                    state_d = ST_MEM;
                else if (op == CL_BRANCH)
                    state_d = ST_FETCH;
                else
                    state_d = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (op == CL_LOAD) state_d = ST_WB;
                    else               state_d = ST_FETCH;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            // The unused code 7 recovers to IDLE.
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        alu_en   = 1'b0;
        dmem_rd  = 1'b0;
        dmem_wr  = 1'b0;
        rf_we    = 1'b0;
        halt     = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        unique case (state_q)
            ST_FETCH: imem_req = 1'b1;
            ST_EXEC: begin
                alu_en = 1'b1;
                if (op == CL_BRANCH) begin
                    pc_load = zero_flag;
                    pc_inc  = !zero_flag;
                end
            end
            ST_MEM: begin
                dmem_rd = (op == CL_LOAD);
                dmem_wr = (op == CL_STORE);
                pc_inc  = (op == CL_STORE) && dmem_ready;
            end
            ST_WB: begin
                rf_we  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_HALTED: halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (state_q == ST_FETCH && imem_ready) begin
            ir <= imem_rdata;
        end
    end

    instr_seq_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (pc_tgt),
        .inc      (pc_inc),
        .pc       (pc)
    );

`ifdef INSTR_SEQ_PERF_EN
    logic        retire;
    logic [31:0] retired_q;

    // An instruction retires when control returns to FETCH from its
    // final phase (branch exec, store mem, or write-back).
    assign retire = (state_d == ST_FETCH) &&
                    (state_q == ST_EXEC ||
                     state_q == ST_MEM  ||
                     state_q == ST_WB);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized self-checking bench for instr_sequencer.
// Per-instruction transaction model: latency, strobe counts, next pc.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [15:0] pc;
    logic        alu_en;
    logic        zero_flag;
    logic        dmem_rd;
    logic        dmem_wr;
    logic        dmem_ready;
    logic        rf_we;
    logic        halt;
    logic [2:0]  state;
    logic [31:0] retired;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_pc;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    instr_sequencer #(
        .PC_W     (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .pc         (pc),
        .alu_en     (alu_en),
        .zero_flag  (zero_flag),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr),
        .dmem_ready (dmem_ready),
        .rf_we      (rf_we),
        .halt       (halt),
        .state      (state),
        .retired    (retired)
    );

    function automatic logic [31:0] exp_retired();
`ifdef INSTR_SEQ_PERF_EN
        return m_ret;
`else
        return 32'd0;
`endif
    endfunction

    // Runs one instruction starting with the DUT observed in FETCH.
    task automatic exec_instr(
        input logic [31:0] instr,
        input int          iw,
        input int          dw,
        input logic        zf
    );
        logic [5:0]  op;
        logic        is_ld, is_st, is_br, is_ht, is_alu;
        int          exp_lat, exp_rd, exp_wr, exp_we, exp_we_at;
        int          exp_alu, exp_alu_at;
        logic [15:0] exp_pc;
        logic [2:0]  exp_st;
        int          cyc, fcnt, mcnt;
        int          n_alu, alu_at, n_rd, n_wr, n_we, we_at;
        bit          fetched, done, both, addr_bad;
        op     = instr[5:0];
        is_ld  = (op == 6'd7);
        is_st  = (op == 6'd8);
        is_br  = (op == 6'd9);
        is_ht  = (op == 6'd63);
        is_alu = !(is_ld || is_st || is_br || is_ht);
        exp_lat = iw + (is_ld ? 5 + dw :
                        is_st ? 4 + dw :
                        is_br ? 3 :
                        is_ht ? 3 : 4);
        exp_rd     = is_ld ? dw + 1 : 0;
        exp_wr     = is_st ? dw + 1 : 0;
        exp_we     = (is_alu || is_ld) ? 1 : 0;
        exp_we_at  = exp_we ? exp_lat : 0;
        exp_alu    = is_ht ? 0 : 1;
        exp_alu_at = is_ht ? 0 : iw + 3;
        if (is_ht)
            exp_pc = m_pc;
        else if (is_br && zf)
            exp_pc = instr[21:6];
        else
            exp_pc = m_pc + 16'd1;
        exp_st = is_ht ? 3'd6 : 3'd1;
        cyc = 0; fcnt = 0; mcnt = 0;
        n_alu = 0; alu_at = 0; n_rd = 0; n_wr = 0;
        n_we = 0; we_at = 0;
        fetched = 0; done = 0; both = 0; addr_bad = 0;
        while (!done && cyc < 100) begin
            if (fetched && imem_req) begin
                done = 1;
            end else begin
                cyc++;
                if (imem_req && imem_addr !== m_pc)
                    addr_bad = 1;
                if (alu_en) begin n_alu++; alu_at = cyc; end
                if (dmem_rd) n_rd++;
                if (dmem_wr) n_wr++;
                if (dmem_rd && dmem_wr) both = 1;
                if (rf_we) begin n_we++; we_at = cyc; end
                if (is_ht && halt) begin
                    done = 1;
                end else begin
                    if (imem_req) begin
                        imem_ready = (fcnt == iw);
                        imem_rdata = imem_ready ? instr : $urandom;
                        if (imem_ready) fetched = 1;
                        fcnt++;
                    end else begin
                        imem_ready = 1'($urandom);
                        imem_rdata = $urandom;
                    end
                    if (dmem_rd || dmem_wr) begin
                        dmem_ready = (mcnt == dw);
                        mcnt++;
                    end else begin
                        dmem_ready = 1'($urandom);
                    end
                    zero_flag = alu_en ? zf : 1'($urandom);
                    run = 1'($urandom);
                    @(negedge clk);
                end
            end
        end
        if (!is_ht) m_ret = m_ret + 32'd1;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL timeout op=%0d cyc=%0d", op, cyc);
        end
        total++;
        if (cyc !== exp_lat) begin
            bad++;
            $display("FAIL latency op=%0d got=%0d exp=%0d",
                     op, cyc, exp_lat);
        end
        total++;
        if (n_alu !== exp_alu || alu_at !== exp_alu_at) begin
            bad++;
            $display("FAIL alu_en op=%0d n=%0d at=%0d exp n=%0d at=%0d",
                     op, n_alu, alu_at, exp_alu, exp_alu_at);
        end
        total++;
        if (n_rd !== exp_rd || n_wr !== exp_wr || both) begin
            bad++;
            $display("FAIL dmem op=%0d rd=%0d wr=%0d exp rd=%0d wr=%0d",
                     op, n_rd, n_wr, exp_rd, exp_wr);
        end
        total++;
        if (n_we !== exp_we || we_at !== exp_we_at) begin
            bad++;
            $display("FAIL rf_we op=%0d n=%0d at=%0d exp n=%0d at=%0d",
                     op, n_we, we_at, exp_we, exp_we_at);
        end
        total++;
        if (pc !== exp_pc || addr_bad) begin
            bad++;
            $display("FAIL pc op=%0d got=%h exp=%h addr_bad=%0d",
                     op, pc, exp_pc, addr_bad);
        end
        total++;
        if (state !== exp_st || ir !== instr) begin
            bad++;
            $display("FAIL state_ir op=%0d st=%0d ir=%h exp st=%0d ir=%h",
                     op, state, ir, exp_st, instr);
        end
        total++;
        if (retired !== exp_retired()) begin
            bad++;
            $display("FAIL retired got=%0d exp=%0d",
                     retired, exp_retired());
        end
        m_pc = exp_pc;
    endtask

    task automatic go_run();
        run        = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        run = 1'b0;
        total++;
        if (state !== 3'd1 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL go_run state=%0d req=%b exp state=1 req=1",
                     state, imem_req);
        end
    endtask

    task automatic test_reset();
        bit idle_bad;
        rst_n      = 1'b0;
        run        = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        zero_flag  = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (state !== 3'd0 || pc !== 16'h0 || ir !== 32'h0 ||
            retired !== 32'h0) begin
            bad++;
            $display("FAIL reset_regs st=%0d pc=%h ir=%h ret=%0d exp 0",
                     state, pc, ir, retired);
        end
        total++;
        if ({imem_req, alu_en, dmem_rd, dmem_wr, rf_we, halt}
            !== 6'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b exp=000000",
                     {imem_req, alu_en, dmem_rd, dmem_wr, rf_we, halt});
        end
        rst_n = 1'b1;
        m_pc  = 16'h0;
        m_ret = 32'h0;
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            @(negedge clk);
            if (state !== 3'd0 || imem_req || alu_en || rf_we ||
                dmem_rd || dmem_wr || halt)
                idle_bad = 1;
        end
        total++;
        if (idle_bad) begin
            bad++;
            $display("FAIL idle_hold got=left_idle exp=stay_idle");
        end
    endtask

    task automatic test_alu();
        go_run();
        exec_instr(32'h0000_0001, 0, 0, 1'b0);
        total++;
        if (pc !== 16'h1) begin
            bad++;
            $display("FAIL alu_pc got=%h exp=0001", pc);
        end
    endtask

    task automatic test_load_wait();
        exec_instr(32'h0000_0007, 0, 3, 1'b0);
    endtask

    task automatic test_store_branch();
        exec_instr(32'h0000_0008, 1, 0, 1'b0);
        exec_instr({10'h0, 16'h0040, 6'd9}, 0, 0, 1'b1);
        total++;
        if (pc !== 16'h0040) begin
            bad++;
            $display("FAIL branch_taken got=%h exp=0040", pc);
        end
        exec_instr({10'h0, 16'h0040, 6'd9}, 0, 0, 1'b0);
        total++;
        if (pc !== 16'h0041) begin
            bad++;
            $display("FAIL branch_not_taken got=%h exp=0041", pc);
        end
    endtask

    task automatic test_wrap();
        exec_instr({10'h0, 16'hFFFF, 6'd9}, 0, 0, 1'b1);
        exec_instr(32'h0000_0002, 0, 0, 1'b0);
        total++;
        if (pc !== 16'h0000) begin
            bad++;
            $display("FAIL pc_wrap got=%h exp=0000", pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] instr;
        logic [5:0]  op;
        int          cls;
        for (int n = 0; n < 150; n++) begin
            cls = $urandom_range(0, 3);
            case (cls)
                0: op = 6'd7;
                1: op = 6'd8;
                2: op = 6'd9;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (op == 6'd7 || op == 6'd8 ||
                           op == 6'd9 || op == 6'd63)
                        op = 6'($urandom_range(0, 63));
                end
            endcase
            instr      = $urandom;
            instr[5:0] = op;
            exec_instr(instr, $urandom_range(0, 3),
                       $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_mem();
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dmem_rd) begin
                seen = 1;
            end else begin
                imem_ready = imem_req;
                imem_rdata = 32'h0000_0007;
                dmem_ready = 1'b0;
                @(negedge clk);
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL mid_mem_reach got=no_dmem_rd exp=dmem_rd");
        end
        rst_n      = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (dmem_rd !== 1'b0 || imem_req !== 1'b0 ||
            state !== 3'd0 || pc !== 16'h0) begin
            bad++;
            $display("FAIL mid_mem_reset rd=%b req=%b st=%0d pc=%h exp 0",
                     dmem_rd, imem_req, state, pc);
        end
        total++;
        if (ir !== 32'h0 || retired !== 32'h0) begin
            bad++;
            $display("FAIL mid_mem_regs ir=%h ret=%0d exp 0",
                     ir, retired);
        end
        rst_n = 1'b1;
        m_pc  = 16'h0;
        m_ret = 32'h0;
    endtask

    task automatic test_halt();
        bit hbad;
        go_run();
        exec_instr(32'h1234_567F | 32'h3F, 1, 0, 1'b0);
        hbad = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            run        = 1'($urandom);
            @(negedge clk);
            if (halt !== 1'b1 || state !== 3'd6 || imem_req ||
                alu_en || dmem_rd || dmem_wr || rf_we)
                hbad = 1;
        end
        total++;
        if (hbad) begin
            bad++;
            $display("FAIL halt_hold got=left_halt exp=halted");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_load_wait();
        test_store_branch();
        test_wrap();
        test_random();
        test_reset_mid_mem();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
